// File: rtl/gray_ptr_if.sv
// gray_ptr_if: local pointer request, remote Gray pointer and status outputs of one
// gray_ptr_ctrl instance. The controller connects through the slave modport.
interface gray_ptr_if #(
  parameter int ADDR_W = 4
);
  logic              inc;
  logic [ADDR_W:0]   remote_gray;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   gray;
  logic              flag;
  logic [ADDR_W:0]   level;
  logic              almost;

  modport master (
    output inc, remote_gray,
    input  addr, gray, flag, level, almost
  );

  modport slave (
    input  inc, remote_gray,
    output addr, gray, flag, level, almost
  );
endinterface

// File: rtl/gray_ptr_ctrl.sv
// gray_ptr_ctrl: async-FIFO pointer controller for one clock domain (IS_WR selects full/empty side).
// Defining GRAY_PTR_LEVEL_EN adds the registered fill level and almost flag.
module gray_ptr_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int IS_WR     = 1,
  parameter int ALMOST_TH = 2
) (
  input logic       clk,
  input logic       rst,
  gray_ptr_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;

  // Inverting the two top Gray bits maps the remote pointer onto "one lap ahead".
  localparam logic [ADDR_W:0] FULL_MASK = PW'(3) << (ADDR_W - 1);
  localparam logic            FLAG_RST  = (IS_WR == 0);

  if (ADDR_W < 1) begin : g_bad_addr_w
    $error("gray_ptr_ctrl: ADDR_W must be at least 1");
  end
  if (ALMOST_TH < 0 || ALMOST_TH > DEPTH) begin : g_bad_almost_th
    $error("gray_ptr_ctrl: ALMOST_TH must lie in 0..DEPTH");
  end

  logic [ADDR_W:0] bin_q, bin_next;
  logic [ADDR_W:0] gray_q, gray_next;
  logic            flag_q, flag_next;
  logic            inc_eff;

  assign inc_eff   = bus.inc & ~flag_q;
  assign bin_next  = bin_q + {{ADDR_W{1'b0}}, inc_eff};
  assign gray_next = bin_next ^ (bin_next >> 1);

  always_comb begin
    if (IS_WR != 0) flag_next = (gray_next == (bus.remote_gray ^ FULL_MASK));
    else            flag_next = (gray_next == bus.remote_gray);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      flag_q <= FLAG_RST;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      flag_q <= flag_next;
    end
  end

  assign bus.addr = bin_q[ADDR_W-1:0];
  assign bus.gray = gray_q;
  assign bus.flag = flag_q;

`ifdef GRAY_PTR_LEVEL_EN
  localparam logic [ADDR_W:0] ALMOST_FULL_TH  = PW'(DEPTH - ALMOST_TH);
  localparam logic [ADDR_W:0] ALMOST_EMPTY_TH = PW'(ALMOST_TH);
  localparam logic            ALMOST_RST      = (IS_WR == 0) || (ALMOST_TH >= DEPTH);

  logic [ADDR_W:0] remote_bin;
  logic [ADDR_W:0] level_next, level_q;
  logic            almost_next, almost_q;

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    remote_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) remote_bin[i] = ^(bus.remote_gray >> i);
  end

  always_comb begin
    if (IS_WR != 0) begin
      level_next  = bin_next - remote_bin;
      almost_next = (level_next >= ALMOST_FULL_TH);
    end else begin
      level_next  = remote_bin - bin_next;
      almost_next = (level_next <= ALMOST_EMPTY_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= '0;
      almost_q <= ALMOST_RST;
    end else begin
      level_q  <= level_next;
      almost_q <= almost_next;
    end
  end

  assign bus.level  = level_q;
  assign bus.almost = almost_q;
`else
  assign bus.level  = '0;
  assign bus.almost = 1'b0;
`endif
endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// tb_gray_ptr_ctrl: vector tables and a wrap sequence against one write-side and one
// read-side gray_ptr_ctrl (ADDR_W=2); expectations queued when driven, popped after the edge.
module tb_gray_ptr_ctrl;
  localparam int AW = 2;
`ifdef GRAY_PTR_LEVEL_EN
  localparam bit LVL_ON = 1'b1;
`else
  localparam bit LVL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_w, rst_r;
  always #5 clk = ~clk;

  gray_ptr_if #(.ADDR_W(AW)) w_if ();
  gray_ptr_if #(.ADDR_W(AW)) r_if ();

  gray_ptr_ctrl #(.ADDR_W(AW), .IS_WR(1), .ALMOST_TH(1)) u_wr (
    .clk(clk), .rst(rst_w), .bus(w_if.slave)
  );
  gray_ptr_ctrl #(.ADDR_W(AW), .IS_WR(0), .ALMOST_TH(2)) u_rd (
    .clk(clk), .rst(rst_r), .bus(r_if.slave)
  );

  typedef struct {
    logic          rst;
    logic          inc;
    logic [AW:0]   rgray;
    logic [AW:0]   gray;
    logic [AW-1:0] addr;
    logic          flag;
    logic [AW:0]   level;
    logic          almost;
  } vec_t;

  typedef struct {
    string         name;
    bit            wr;
    logic [AW:0]   gray;
    logic [AW-1:0] addr;
    logic          flag;
    logic [AW:0]   level;
    logic          almost;
  } exp_t;

  exp_t sb[$];
  int   n_vec     = 0;
  int   n_miscmp  = 0;

  function automatic vec_t mk(logic r, logic i, logic [AW:0] rg, logic [AW:0] g,
                              logic [AW-1:0] a, logic f, logic [AW:0] l, logic al);
    vec_t v;
    v.rst = r; v.inc = i; v.rgray = rg; v.gray = g;
    v.addr = a; v.flag = f; v.level = l; v.almost = al;
    return v;
  endfunction

  function automatic logic [AW:0] to_gray(int b);
    logic [AW:0] x;
    x = (AW + 1)'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    if (e.wr) begin
      check({e.name, ".gray"},   32'(w_if.gray),   32'(e.gray));
      check({e.name, ".addr"},   32'(w_if.addr),   32'(e.addr));
      check({e.name, ".flag"},   32'(w_if.flag),   32'(e.flag));
      check({e.name, ".level"},  32'(w_if.level),  32'(e.level));
      check({e.name, ".almost"}, 32'(w_if.almost), 32'(e.almost));
    end else begin
      check({e.name, ".gray"},   32'(r_if.gray),   32'(e.gray));
      check({e.name, ".addr"},   32'(r_if.addr),   32'(e.addr));
      check({e.name, ".flag"},   32'(r_if.flag),   32'(e.flag));
      check({e.name, ".level"},  32'(r_if.level),  32'(e.level));
      check({e.name, ".almost"}, 32'(r_if.almost), 32'(e.almost));
    end
  endtask

  task automatic apply(bit wr, string name, vec_t v);
    exp_t e;
    @(negedge clk);
    if (wr) begin
      rst_w = v.rst; w_if.inc = v.inc; w_if.remote_gray = v.rgray;
    end else begin
      rst_r = v.rst; r_if.inc = v.inc; r_if.remote_gray = v.rgray;
    end
    e.name   = name;
    e.wr     = wr;
    e.gray   = v.gray;
    e.addr   = v.addr;
    e.flag   = v.flag;
    e.level  = LVL_ON ? v.level : '0;
    e.almost = LVL_ON ? v.almost : 1'b0;
    sb.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t wvec[15];
    vec_t rvec[5];
    logic [AW:0] prev_gray;

    // Write side, ALMOST_TH=1: fill, dropped 5th inc, simultaneous release, reset mid-run.
    wvec[0]  = mk(1, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    wvec[1]  = mk(0, 1, 3'b000, 3'b001, 1, 0, 1, 0);
    wvec[2]  = mk(0, 1, 3'b000, 3'b011, 2, 0, 2, 0);
    wvec[3]  = mk(0, 1, 3'b000, 3'b010, 3, 0, 3, 1);
    wvec[4]  = mk(0, 1, 3'b000, 3'b110, 0, 1, 4, 1);
    wvec[5]  = mk(0, 1, 3'b000, 3'b110, 0, 1, 4, 1);
    wvec[6]  = mk(0, 1, 3'b001, 3'b110, 0, 0, 3, 1);
    wvec[7]  = mk(0, 1, 3'b001, 3'b111, 1, 1, 4, 1);
    wvec[8]  = mk(0, 1, 3'b001, 3'b111, 1, 1, 4, 1);
    wvec[9]  = mk(1, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    wvec[10] = mk(0, 1, 3'b000, 3'b001, 1, 0, 1, 0);
    wvec[11] = mk(0, 1, 3'b000, 3'b011, 2, 0, 2, 0);
    wvec[12] = mk(0, 1, 3'b000, 3'b010, 3, 0, 3, 1);
    wvec[13] = mk(1, 1, 3'b000, 3'b000, 0, 0, 0, 0);
    wvec[14] = mk(0, 1, 3'b000, 3'b001, 1, 0, 1, 0);

    // Read side, ALMOST_TH=2: empty after reset, inc blocked, remote move, inc to empty.
    rvec[0]  = mk(1, 0, 3'b000, 3'b000, 0, 1, 0, 1);
    rvec[1]  = mk(0, 1, 3'b000, 3'b000, 0, 1, 0, 1);
    rvec[2]  = mk(0, 1, 3'b000, 3'b000, 0, 1, 0, 1);
    rvec[3]  = mk(0, 0, 3'b001, 3'b000, 0, 0, 1, 1);
    rvec[4]  = mk(0, 1, 3'b001, 3'b001, 1, 1, 0, 1);

    rst_w = 1'b1; rst_r = 1'b1;
    w_if.inc = 1'b0; w_if.remote_gray = '0;
    r_if.inc = 1'b0; r_if.remote_gray = '0;

    for (int i = 0; i < 15; i++) apply(1'b1, $sformatf("wr_vec%0d", i), wvec[i]);
    for (int i = 0; i < 5; i++)  apply(1'b0, $sformatf("rd_vec%0d", i), rvec[i]);

    // Wrap: remote leads by one each cycle, local incs one cycle behind for 8 increments.
    apply(1'b0, "wrap_rst", mk(1, 0, 3'b000, 3'b000, 0, 1, 0, 1));
    prev_gray = r_if.gray;
    for (int k = 1; k <= 9; k++) begin
      int rk, b, lvl;
      rk  = (k > 8 ? 8 : k) & 7;
      b   = (k >= 2) ? k - 1 : 0;
      lvl = (rk - (b & 7)) & 7;
      apply(1'b0, $sformatf("wrap%0d", k),
            mk(0, (k >= 2), to_gray(rk), to_gray(b & 7), AW'(b & 3),
               ((b & 7) == rk), (AW + 1)'(lvl), (lvl <= 2)));
      if (k >= 2) check($sformatf("wrap%0d.onebit", k), 32'($countones(r_if.gray ^ prev_gray)), 32'd1);
      prev_gray = r_if.gray;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
